// File: rtl/adc_sample_sequencer_pkg.sv
// Shared constants for the ADC sample sequencer and its averager.
//   DATA_W    : ADC result / average width
//   AVG_RESET : average value after reset (coolest code, LEDs show minimum)
//   TEMP_CODE_*: temperature code points from temp_codes.vh
package adc_sample_sequencer_pkg;
    `include "temp_codes.vh"

    localparam int unsigned       DATA_W    = 12;
    localparam logic [DATA_W-1:0] AVG_RESET = 12'd4095;
endpackage

// File: rtl/sample_averager.sv
// Accumulates 2**AVG_LOG2 samples and publishes their truncated mean.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : drop the partial accumulation (average registers hold)
//   sample_valid : capture sample this cycle
//   sample       : raw ADC code
//   avg_dout     : latest average (registered)
//   avg_valid    : one-cycle pulse when avg_dout updates (registered)
//   avg_next_c   : combinational value avg_dout takes when avg_load_c is high
//   avg_load_c   : combinational, high when this edge writes avg_dout
module sample_averager
    import adc_sample_sequencer_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg_dout,
    output logic              avg_valid,
    output logic [DATA_W-1:0] avg_next_c,
    output logic              avg_load_c
);
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned LAST  = (1 << AVG_LOG2) - 1;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] sum_c;
    logic             last_c;

    // Accumulator width is sized so the full sum of a window never overflows.
    always_comb begin
        sum_c      = acc + ACC_W'(sample);
        last_c     = (count == CNT_W'(LAST));
        avg_load_c = sample_valid && last_c && !flush;
        avg_next_c = DATA_W'(sum_c >> AVG_LOG2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            avg_dout  <= AVG_RESET;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= avg_load_c;
            if (flush) begin
                acc   <= '0;
                count <= '0;
            end else if (sample_valid) begin
                if (last_c) begin
                    acc      <= '0;
                    count    <= '0;
                    avg_dout <= avg_next_c;
                end else begin
                    acc   <= sum_c;
                    count <= count + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/temp_codes.vh
// Temperature code points shared by the LED mapper and the ADC sample sequencer.
// A lower ADC code means a hotter sensor; TEMP_CODE_0 is 80 C, each later point is cooler.
`ifndef TEMP_CODES_VH
`define TEMP_CODES_VH
localparam int unsigned TEMP_CODE_0 = 3550;
localparam int unsigned TEMP_CODE_1 = 3576;
localparam int unsigned TEMP_CODE_2 = 3595;
localparam int unsigned TEMP_CODE_3 = 3625;
localparam int unsigned TEMP_CODE_4 = 3643;
localparam int unsigned TEMP_CODE_5 = 3666;
`endif

// File: rtl/adc_sample_sequencer.sv
// Periodic temperature-ADC conversion controller with averaging, an
// over-temperature flag with hysteresis and a sticky timeout error.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : run the sampling loop
//   adc_req     : conversion request, high until acknowledged or timed out
//   adc_valid   : conversion complete, adc_data valid same cycle
//   adc_data    : raw conversion result
//   clear_err   : clears timeout_err (a simultaneous timeout wins)
//   avg_dout    : latest average, drives the LED mapper
//   avg_valid   : one-cycle pulse when avg_dout updates
//   overtemp    : average at/below OVERTEMP_CODE, cleared above OVERTEMP_CODE+HYST
//   timeout_err : sticky conversion-timeout error
module adc_sample_sequencer
    import adc_sample_sequencer_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 50000,
    parameter int unsigned AVG_LOG2      = 3,
    parameter int unsigned TIMEOUT       = 1024,
    parameter int unsigned OVERTEMP_CODE = TEMP_CODE_0,
    parameter int unsigned HYST          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              adc_req,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              clear_err,
    output logic [DATA_W-1:0] avg_dout,
    output logic              avg_valid,
    output logic              overtemp,
    output logic              timeout_err
);
    localparam int unsigned PER_W      = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned TO_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CLEAR_CODE = OVERTEMP_CODE + HYST;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             req_d, err_d, ot_d;
    logic             sample_valid_c;
    logic             timeout_c;
    logic [DATA_W-1:0] avg_next_c;
    logic             avg_load_c;

    // Next-state, counter and flag logic; enable low overrides every state.
    always_comb begin
        state_d        = state_q;
        per_d          = per_q;
        to_d           = to_q;
        err_d          = timeout_err;
        ot_d           = overtemp;
        sample_valid_c = 1'b0;
        timeout_c      = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    per_d   = PER_W'(SAMPLE_PERIOD - 1);
                end
                ST_WAIT: begin
                    if (per_q == '0) begin
                        state_d = ST_CONV;
                        to_d    = TO_W'(TIMEOUT - 1);
                    end else begin
                        per_d = per_q - 1'b1;
                    end
                end
                ST_CONV: begin
                    if (adc_valid) begin
                        sample_valid_c = 1'b1;
                        state_d        = ST_WAIT;
                        per_d          = PER_W'(SAMPLE_PERIOD - 1);
                    end else if (to_q == '0) begin
                        timeout_c = 1'b1;
                        state_d   = ST_WAIT;
                        per_d     = PER_W'(SAMPLE_PERIOD - 1);
                    end else begin
                        to_d = to_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        req_d = (state_d == ST_CONV);

        if (timeout_c) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end

        // Hysteresis evaluated on the average being written this edge.
        if (avg_load_c) begin
            if (32'(avg_next_c) <= OVERTEMP_CODE) begin
                ot_d = 1'b1;
            end else if (32'(avg_next_c) > CLEAR_CODE) begin
                ot_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            per_q       <= '0;
            to_q        <= '0;
            adc_req     <= 1'b0;
            timeout_err <= 1'b0;
            overtemp    <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            to_q        <= to_d;
            adc_req     <= req_d;
            timeout_err <= err_d;
            overtemp    <= ot_d;
        end
    end

    sample_averager #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .clk         (clk),
        .rst         (rst),
        .flush       (!enable),
        .sample_valid(sample_valid_c),
        .sample      (adc_data),
        .avg_dout    (avg_dout),
        .avg_valid   (avg_valid),
        .avg_next_c  (avg_next_c),
        .avg_load_c  (avg_load_c)
    );
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Scoreboard bench for adc_sample_sequencer (averaging instance and a
// straight-through AVG_LOG2=0 instance).
module tb_adc_sample_sequencer;
    localparam int SP = 10;
    localparam int TO = 8;

    typedef struct {
        logic [11:0] avg;
        logic        ot;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, adc_valid, clear_err;
    logic [11:0] adc_data;
    logic        adc_req, avg_valid, overtemp, timeout_err;
    logic [11:0] avg_dout;

    logic        enable0, adc_valid0, clear_err0;
    logic [11:0] adc_data0;
    logic        adc_req0, avg_valid0, overtemp0, timeout_err0;
    logic [11:0] avg_dout0;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t exp0_q[$];

    always #5 clk = ~clk;

    adc_sample_sequencer #(
        .SAMPLE_PERIOD(SP), .AVG_LOG2(2), .TIMEOUT(TO), .OVERTEMP_CODE(3550), .HYST(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .adc_req(adc_req),
        .adc_valid(adc_valid), .adc_data(adc_data), .clear_err(clear_err),
        .avg_dout(avg_dout), .avg_valid(avg_valid), .overtemp(overtemp),
        .timeout_err(timeout_err)
    );

    adc_sample_sequencer #(
        .SAMPLE_PERIOD(SP), .AVG_LOG2(0), .TIMEOUT(TO), .OVERTEMP_CODE(3550), .HYST(16)
    ) dut0 (
        .clk(clk), .rst(rst), .enable(enable0), .adc_req(adc_req0),
        .adc_valid(adc_valid0), .adc_data(adc_data0), .clear_err(clear_err0),
        .avg_dout(avg_dout0), .avg_valid(avg_valid0), .overtemp(overtemp0),
        .timeout_err(timeout_err0)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: every avg_valid pulse must match the oldest expected average.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && avg_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_avg_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("avg_dout", int'(avg_dout), int'(e.avg));
                check("overtemp", int'(overtemp), int'(e.ot));
            end
        end
    end

    always @(negedge clk) begin : mon0
        exp_t e;
        if (!rst && avg_valid0) begin
            if (exp0_q.size() == 0) begin
                check("unexpected_avg_valid0", 1, 0);
            end else begin
                e = exp0_q.pop_front();
                check("avg_dout0", int'(avg_dout0), int'(e.avg));
                check("overtemp0", int'(overtemp0), int'(e.ot));
            end
        end
    end

    // Wait for a request, hold it dly extra cycles, then acknowledge with d.
    task automatic sample(input logic [11:0] d, input int dly, output int wait_n, output int len);
        wait_n = 0;
        len    = 0;
        while (!adc_req && wait_n < 100) begin
            tick();
            wait_n++;
        end
        if (!adc_req) begin
            check("req_never_rose", 0, 1);
            return;
        end
        len = 1;
        repeat (dly) begin
            tick();
            if (adc_req) len++;
        end
        adc_valid = 1'b1;
        adc_data  = d;
        tick();
        adc_valid = 1'b0;
        check("req_drop_on_ack", int'(adc_req), 0);
    endtask

    task automatic sample4(input logic [11:0] s0, input logic [11:0] s1,
                           input logic [11:0] s2, input logic [11:0] s3,
                           input logic [11:0] ea, input logic eo,
                           input int dly, input int first);
        logic [11:0] s[4];
        exp_t        e;
        int          w, l;
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                e.avg = ea;
                e.ot  = eo;
                exp_q.push_back(e);
            end
            sample(s[i], dly, w, l);
            if (i == 0) begin
                if (first >= 0) check("first_req_wait", w, first);
            end else begin
                check("req_interval", w, SP);
            end
            check("req_len", l, dly + 1);
        end
    endtask

    task automatic do_timeout(input logic clr, input int first);
        int w, l;
        w = 0;
        while (!adc_req && w < 100) begin
            tick();
            w++;
        end
        check("to_first_wait", w, first);
        l = 1;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (adc_req) l++;
        end
        check("err_before_timeout", int'(timeout_err), 0);
        clear_err = clr;
        tick();
        clear_err = 1'b0;
        check("to_req_len", l, TO);
        check("to_req_drop", int'(adc_req), 0);
        check("timeout_err_set", int'(timeout_err), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   w, l;
        exp_t e;
        rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_data = '0; clear_err = 1'b0;
        enable0 = 1'b0; adc_valid0 = 1'b0; adc_data0 = '0; clear_err0 = 1'b0;
        repeat (3) tick();
        check("rst_adc_req", int'(adc_req), 0);
        check("rst_avg_dout", int'(avg_dout), 4095);
        check("rst_avg_valid", int'(avg_valid), 0);
        check("rst_overtemp", int'(overtemp), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        check("rst_avg_dout0", int'(avg_dout0), 4095);

        // Request timing and averaging (ack 2 clocks after each rise).
        rst = 1'b0;
        enable = 1'b1;
        tick();
        sample4(12'd3600, 12'd3601, 12'd3602, 12'd3605, 12'd3602, 1'b0, 2, SP);

        // Over-temperature hysteresis with immediate acks; includes boundary codes.
        sample4(12'd3540, 12'd3540, 12'd3540, 12'd3540, 12'd3540, 1'b1, 0, SP);
        sample4(12'd3560, 12'd3561, 12'd3559, 12'd3563, 12'd3560, 1'b1, 0, SP);
        sample4(12'd3570, 12'd3570, 12'd3570, 12'd3570, 12'd3570, 1'b0, 0, SP);
        sample4(12'd3566, 12'd3566, 12'd3566, 12'd3566, 12'd3566, 1'b0, 0, SP);
        sample4(12'd3550, 12'd3550, 12'd3550, 12'd3550, 12'd3550, 1'b1, 0, SP);
        sample4(12'd3566, 12'd3566, 12'd3566, 12'd3566, 12'd3566, 1'b1, 0, SP);
        sample4(12'd3567, 12'd3567, 12'd3567, 12'd3567, 12'd3567, 1'b0, 0, SP);

        // Timeout, clear, fresh window, then timeout racing clear_err.
        do_timeout(1'b0, SP);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("timeout_err_cleared", int'(timeout_err), 0);
        sample4(12'd100, 12'd200, 12'd300, 12'd400, 12'd250, 1'b1, 0, SP - 1);
        do_timeout(1'b1, SP);

        // Disable after two samples; the next average uses four fresh samples.
        sample(12'd1000, 0, w, l);
        check("dis_wait1", w, SP);
        sample(12'd1000, 0, w, l);
        check("dis_wait2", w, SP);
        enable = 1'b0;
        tick();
        check("dis_adc_req", int'(adc_req), 0);
        check("dis_avg_hold", int'(avg_dout), 250);
        check("dis_ot_hold", int'(overtemp), 1);
        check("dis_err_hold", int'(timeout_err), 1);
        repeat (3) tick();
        enable = 1'b1;
        tick();
        sample4(12'd2000, 12'd2001, 12'd2002, 12'd2003, 12'd2001, 1'b1, 0, SP);

        // Reset during CONV, then a late acknowledge that must be ignored.
        w = 0;
        while (!adc_req && w < 100) begin
            tick();
            w++;
        end
        check("conv_before_rst", int'(adc_req), 1);
        rst = 1'b1;
        tick();
        check("midrst_adc_req", int'(adc_req), 0);
        check("midrst_avg_dout", int'(avg_dout), 4095);
        check("midrst_overtemp", int'(overtemp), 0);
        check("midrst_timeout_err", int'(timeout_err), 0);
        rst = 1'b0;
        adc_valid = 1'b1;
        adc_data  = 12'd5;
        tick();
        tick();
        adc_valid = 1'b0;
        sample4(12'd3000, 12'd3000, 12'd3000, 12'd3000, 12'd3000, 1'b1, 0, SP - 1);

        // Straight-through instance: each sample appears one cycle after adc_valid.
        enable0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            w = 0;
            while (!adc_req0 && w < 100) begin
                tick();
                w++;
            end
            check("req0_rose", int'(adc_req0), 1);
            e.avg = (i == 0) ? 12'd3666 : 12'd3500;
            e.ot  = (i == 0) ? 1'b0 : 1'b1;
            exp0_q.push_back(e);
            adc_valid0 = 1'b1;
            adc_data0  = e.avg;
            tick();
            adc_valid0 = 1'b0;
            check("pass_avg_valid0", int'(avg_valid0), 1);
            check("pass_avg_dout0", int'(avg_dout0), int'(e.avg));
        end

        repeat (3) tick();
        check("exp_q_drained", exp_q.size(), 0);
        check("exp0_q_drained", exp0_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_sample_sequencer.md
# adc_sample_sequencer

Periodic conversion controller for the on-board temperature ADC. It requests a conversion every `SAMPLE_PERIOD` clocks and collects each result over a valid handshake. It averages `2**AVG_LOG2` results and presents the average on a 12-bit bus that drives the temperature-to-LED mapper's `adc_dout` input. It also raises an over-temperature flag with hysteresis and a sticky conversion-timeout error.

## Interface
Clock is `clk`; reset is `rst`. Reset is synchronous and active-high.

Parameters:
- `SAMPLE_PERIOD`, default 50000: clocks from entering WAIT to the next `adc_req` assertion; minimum 2.
- `AVG_LOG2`, default 3: log2 of the number of samples per average; range 0..4.
- `TIMEOUT`, default 1024: maximum number of clocks in CONV before the conversion is abandoned.
- `OVERTEMP_CODE`, default 3550: ADC code at or below which the block is over temperature. A lower code means hotter; 3550 corresponds to 80 °C.
- `HYST`, default 16: number of codes above `OVERTEMP_CODE` required before `overtemp` clears.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: synchronous, active-high reset.
- `enable`, input, 1: run the sampling loop.
- `adc_req`, output, 1: conversion request, held high until acknowledged.
- `adc_valid`, input, 1: conversion complete; `adc_data` is valid in the same cycle.
- `adc_data`, input, 12: raw conversion result.
- `clear_err`, input, 1: clears `timeout_err`.
- `avg_dout`, output, 12: latest average; feeds the LED mapper.
- `avg_valid`, output, 1: one-cycle pulse when `avg_dout` updates.
- `overtemp`, output, 1: over-temperature flag, with hysteresis.
- `timeout_err`, output, 1: sticky error; set when a conversion times out.

## Operation
FSM states: IDLE, WAIT, CONV.
- **IDLE.** `adc_req` is 0. Move to WAIT when `enable` is 1, and load the period counter with `SAMPLE_PERIOD-1`.
- **WAIT.** The period counter decrements each clock. When it reaches 0, move to CONV and load the timeout counter with `TIMEOUT-1`.
- **CONV.** `adc_req` is 1. `adc_valid` is sampled only in this state; in IDLE and WAIT it is ignored.
  - If `adc_valid` is 1: add `adc_data` to the accumulator, increment the sample count, and return to WAIT with the period counter reloaded.
  - Otherwise, if the timeout counter is 0: set `timeout_err`, discard the attempt (accumulator and count unchanged), and return to WAIT with the period counter reloaded.
- **`enable` low in any state.** Move to IDLE on the next edge. `adc_req` drops, the accumulator and sample count clear, and `avg_dout`, `overtemp` and `timeout_err` hold their values.
- **Accumulator.** Width is 12+`AVG_LOG2` bits, so it cannot overflow.
- **Average completion.** On the edge that captures the `2**AVG_LOG2`-th sample:
  - `avg_dout` ← (accumulator + `adc_data`) >> `AVG_LOG2`, truncating;
  - `avg_valid` ← 1;
  - the accumulator and count clear.
- **`AVG_LOG2` = 0.** Every sample passes straight through to `avg_dout`.
- **`overtemp`.** Updated only on the edge that writes `avg_dout`, using the new average:
  - set if the average ≤ `OVERTEMP_CODE`;
  - clear if the average > `OVERTEMP_CODE` + `HYST`;
  - otherwise hold.
- **`timeout_err` priority.** If a timeout and `clear_err` occur in the same cycle, set wins.

## Timing
- **Reset values:**
  - state IDLE;
  - `adc_req` 0;
  - `avg_dout` 12'd4095, the coolest code, so the LEDs show minimum temperature;
  - `avg_valid` 0;
  - `overtemp` 0;
  - `timeout_err` 0;
  - accumulator, count and all counters 0.
- **Reset mid-conversion** has the same effect as above; a late `adc_valid` arriving after reset is ignored.
- **First request.** If `enable` is first seen high at edge e, `adc_req` rises after edge e+`SAMPLE_PERIOD`.
- **Request/acknowledge.** If `adc_valid` is seen high at edge k, `adc_req` is low from edge k. `avg_valid` (when due) is high for the single cycle after edge k.
- **Sample interval.** With immediate acknowledgement, requests are spaced `SAMPLE_PERIOD`+1 clocks apart.
- **Timeout point.** If `adc_valid` never arrives, `adc_req` stays high for exactly `TIMEOUT` cycles, then falls and `timeout_err` rises on the same edge.
- **Outputs** are all registered, with no combinational path from an input to an output.

## Structure
- The temperature code points (3550, 3576, 3595, 3625, 3643, 3666) go in a shared `temp_codes.vh` include. The LED mapper and this block both use it, and `OVERTEMP_CODE` defaults from it.
- The FSM state encoding stays as localparams inside this block.
- Sub-module `sample_averager` contains the accumulator, sample count, shift, and the `avg_dout`/`avg_valid` registers. Its inputs are `clk`, `rst`, `flush`, `sample_valid` and `sample`.
- The sequencer FSM, period/timeout counters, `overtemp` and `timeout_err` logic stay in the top level.

## Test plan
All scenarios use `SAMPLE_PERIOD`=10, `AVG_LOG2`=2, `TIMEOUT`=8 unless noted.
1. **Period and request timing.** After reset, set `enable`=1 and acknowledge each request 2 clocks after it rises. Required: the first `adc_req` is 10 clocks after enable, and each request lasts 3 cycles.
2. **Averaging.** Supply samples 3600, 3601, 3602, 3605. Required: one `avg_valid` pulse with `avg_dout`=3602, and no pulse after the first three samples.
3. **Over-temperature hysteresis.** Drive successive averages 3540, 3560, 3570. Required: `overtemp` goes 1, stays 1 (3560 ≤ 3566), then goes 0.
4. **Timeout.** Never assert `adc_valid`. Required: `adc_req` is high for 8 cycles and then `timeout_err`=1. The next good sample counts as sample 1 of 4. Asserting `clear_err` in the same cycle as a second timeout leaves `timeout_err`=1.
5. **Disable and reset mid-operation.** Drop `enable` after 2 samples and re-enable. Required: the next average uses 4 fresh samples. Asserting `rst` during CONV returns `avg_dout` to 4095 and `adc_req` to 0 on the next edge.
6. **Straight-through mode.** With `AVG_LOG2`=0, sample 3666 gives `avg_dout`=3666 one cycle after `adc_valid`.
